pc_fetch_unit: RTL and testbench

- Consumer end of the branch/jump redirect interface. Owns the architectural fetch PC.
- Accepts pc_src/new_pc from the execute-stage PC logic and issues one-at-a-time instruction-memory requests (valid/ready).
- Discards stale responses after a redirect.
- Presents fetched instructions to the IF/ID latch through a valid/ready handshake, and flushes younger stages on redirect.

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 94 +++++++++
 tb/tb_pc_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch unit: redirect select values, FSM states and reset PC default.
package pc_fetch_unit_pkg;

  localparam logic PC_PLUS4 = 1'b0;
  localparam logic NEW_PC   = 1'b1;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_instr;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_instr
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_instr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC owner: issues one-at-a-time imem requests, drops stale responses after a redirect,
// and holds each fetched instruction on if_* until the IF/ID latch accepts it.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_src,
  input  logic [XLEN-1:0]  new_pc,
  input  logic             stall,
  pc_fetch_unit_if.master  imem,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic [XLEN-1:0]  if_instr,
  input  logic             if_ready,
  output logic             flush,
  output logic [XLEN-1:0]  fetch_pc
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            drop_q;
  logic            redirect;

  assign redirect            = (pc_src == NEW_PC);
  assign flush               = rst_n && redirect;
  assign imem.imem_req_valid = rst_n && (state_q == S_REQ) && !stall && !redirect;
  assign imem.imem_req_addr  = pc_q;
  assign fetch_pc            = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (redirect) begin
      pc_q     <= new_pc & ~XLEN'(3);
      if_valid <= 1'b0;
      unique case (state_q)
        S_REQ: state_q <= S_REQ;
        S_WAIT: begin
          // A response arriving with the redirect is consumed here, so nothing stale remains.
          if (imem.imem_resp_valid) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        S_HOLD:  state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem.imem_req_valid && imem.imem_req_ready) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + XLEN'(4);
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              if_valid <= 1'b1;
              if_pc    <= req_pc_q;
              if_instr <= imem.imem_resp_instr;
              state_q  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (if_ready) begin
            if_valid <= 1'b0;
            state_q  <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: the bench plays instruction memory and checks if_* against
// a scoreboard of {pc, instr} pairs pushed whenever it returns a response that must survive.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] new_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic [31:0] fetch_pc;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  pc_fetch_unit_if #(.XLEN(32)) imem_bus ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_src   (pc_src),
    .new_pc   (new_pc),
    .stall    (stall),
    .imem     (imem_bus),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_ready (if_ready),
    .flush    (flush),
    .fetch_pc (fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // IF/ID handshake this cycle: compare if_* with the oldest expected pair.
  task automatic consume();
    logic [63:0] e;
    chk("if_valid_hs", {31'd0, if_valid}, 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("if_pc", if_pc, e[63:32]);
      chk("if_instr", if_instr, e[31:0]);
    end
  endtask

  // One sequential fetch with a one-cycle memory response, starting in S_REQ with if_ready=1.
  task automatic fetch_seq(input logic [31:0] addr);
    settle();
    chk("req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd1);
    chk("req_addr", imem_bus.imem_req_addr, addr);
    step();
    chk("req_valid_wait", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_instr = instr_of(addr);
    sb.push_back({addr, instr_of(addr)});
    settle();
    step();
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_instr = '0;
    settle();
    consume();
    chk("req_valid_hold", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    step();
  endtask

  initial begin
    rst_n                    = 1'b0;
    pc_src                   = PC_PLUS4;
    new_pc                   = '0;
    stall                    = 1'b0;
    if_ready                 = 1'b1;
    imem_bus.imem_req_ready  = 1'b1;
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_instr = '0;

    // Reset: outputs quiet, flush masked even with a redirect request.
    step();
    step();
    pc_src = NEW_PC;
    new_pc = 32'h0000_0ABC;
    settle();
    chk("rst_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    step();
    pc_src = PC_PLUS4;
    rst_n  = 1'b1;

    // Sequential fetch 0x0, 0x4, 0x8.
    fetch_seq(32'h0);
    fetch_seq(32'h4);
    fetch_seq(32'h8);

    // Stall in S_REQ for 5 cycles.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
      chk("stall_fetch_pc", fetch_pc, 32'h0000_000C);
      step();
    end
    stall = 1'b0;
    settle();
    chk("req_addr_c", imem_bus.imem_req_addr, 32'h0000_000C);
    step();
    // Stall raised while waiting: response must still be captured.
    stall = 1'b1;
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_instr = instr_of(32'hC);
    sb.push_back({32'hC, instr_of(32'hC)});
    settle();
    step();
    imem_bus.imem_resp_valid = 1'b0;
    settle();
    consume();
    step();
    settle();
    chk("stall_after_hold", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    stall = 1'b0;

    // Memory not ready: request held stable, PC not advanced.
    imem_bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("nready_valid", {31'd0, imem_bus.imem_req_valid}, 32'd1);
      chk("nready_addr", imem_bus.imem_req_addr, 32'h0000_0010);
      step();
    end
    imem_bus.imem_req_ready = 1'b1;

    // Redirect while 0x10 is outstanding: its response is dropped.
    settle();
    chk("req_addr_10", imem_bus.imem_req_addr, 32'h0000_0010);
    step();
    pc_src = NEW_PC;
    new_pc = 32'h0000_0200;
    settle();
    chk("redir_flush", {31'd0, flush}, 32'd1);
    chk("redir_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    step();
    pc_src = PC_PLUS4;
    settle();
    chk("redir_flush_off", {31'd0, flush}, 32'd0);
    chk("redir_fetch_pc", fetch_pc, 32'h0000_0200);
    chk("redir_wait_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    step();
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_instr = instr_of(32'h10);
    settle();
    step();
    imem_bus.imem_resp_valid = 1'b0;
    settle();
    chk("drop_if_valid", {31'd0, if_valid}, 32'd0);
    fetch_seq(32'h0000_0200);

    // Redirect in the same cycle as the response.
    settle();
    chk("req_addr_204", imem_bus.imem_req_addr, 32'h0000_0204);
    step();
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_instr = instr_of(32'h204);
    pc_src = NEW_PC;
    new_pc = 32'h0000_0300;
    settle();
    chk("same_flush", {31'd0, flush}, 32'd1);
    step();
    imem_bus.imem_resp_valid = 1'b0;
    pc_src = PC_PLUS4;
    settle();
    chk("same_if_valid", {31'd0, if_valid}, 32'd0);
    fetch_seq(32'h0000_0300);

    // Redirect in S_HOLD with if_ready=1: not a handshake.
    settle();
    step();
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_instr = instr_of(32'h304);
    settle();
    step();
    imem_bus.imem_resp_valid = 1'b0;
    pc_src = NEW_PC;
    new_pc = 32'h0000_0400;
    settle();
    chk("hold_if_valid", {31'd0, if_valid}, 32'd1);
    chk("hold_flush", {31'd0, flush}, 32'd1);
    step();
    pc_src = PC_PLUS4;
    settle();
    chk("hold_redir_if_valid", {31'd0, if_valid}, 32'd0);
    chk("hold_sb_empty", 32'(sb.size()), 32'd0);
    fetch_seq(32'h0000_0400);

    // Backpressure in S_HOLD for 4 cycles.
    settle();
    chk("req_addr_404", imem_bus.imem_req_addr, 32'h0000_0404);
    step();
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_instr = instr_of(32'h404);
    sb.push_back({32'h404, instr_of(32'h404)});
    settle();
    step();
    imem_bus.imem_resp_valid = 1'b0;
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_if_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_if_pc", if_pc, 32'h0000_0404);
      chk("bp_if_instr", if_instr, instr_of(32'h404));
      chk("bp_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
      step();
    end
    if_ready = 1'b1;
    settle();
    consume();
    step();
    fetch_seq(32'h0000_0408);

    // Back-to-back redirects while waiting: last target wins, stale response dropped.
    settle();
    chk("req_addr_40c", imem_bus.imem_req_addr, 32'h0000_040C);
    step();
    pc_src = NEW_PC;
    new_pc = 32'h0000_0500;
    settle();
    step();
    new_pc = 32'h0000_0600;
    settle();
    chk("b2b_flush", {31'd0, flush}, 32'd1);
    step();
    pc_src = PC_PLUS4;
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_instr = instr_of(32'h40C);
    settle();
    chk("b2b_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    step();
    imem_bus.imem_resp_valid = 1'b0;
    settle();
    chk("b2b_if_valid", {31'd0, if_valid}, 32'd0);
    fetch_seq(32'h0000_0600);

    // Misaligned target is word-aligned; fetch wraps at the top of the address space.
    pc_src = NEW_PC;
    new_pc = 32'h0000_0103;
    settle();
    chk("align_req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    chk("align_flush", {31'd0, flush}, 32'd1);
    step();
    pc_src = PC_PLUS4;
    settle();
    chk("align_fetch_pc", fetch_pc, 32'h0000_0100);
    fetch_seq(32'h0000_0100);
    pc_src = NEW_PC;
    new_pc = 32'hFFFF_FFFC;
    settle();
    step();
    pc_src = PC_PLUS4;
    fetch_seq(32'hFFFF_FFFC);
    settle();
    chk("wrap_fetch_pc", fetch_pc, 32'h0000_0000);
    fetch_seq(32'h0000_0000);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
